// File: rtl/glb_ld_strm_tx.sv
// glb_ld_strm_tx: GLB load-stream transmitter; buffers GLB read words and emits
// them on the g2io lanes using an affine VALID schedule or a READY_VALID handshake.
module glb_ld_strm_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LOOP_LEVEL = 3,
  parameter int CNT_WIDTH  = 20,
  parameter int EXT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_cfg_start,
  input  logic [1:0]                       i_cfg_mode,
  input  logic [$clog2(LOOP_LEVEL+1)-1:0]  i_cfg_dim,
  input  logic [LOOP_LEVEL*EXT_WIDTH-1:0]  i_cfg_extent,
  input  logic [LOOP_LEVEL*CNT_WIDTH-1:0]  i_cfg_cycle_stride,
  input  logic                             i_stall,
  input  logic                             i_flush,
  input  logic [DATA_WIDTH-1:0]            i_src_data,
  input  logic                             i_src_vld,
  output logic                             o_src_rdy,
  output logic                             o_io1_g2io,
  output logic [DATA_WIDTH-1:0]            o_io16_g2io,
  output logic                             o_io16_g2io_vld,
  input  logic                             i_io16_g2io_rdy,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err_underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(LOOP_LEVEL+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                r_state, w_nstate;
  logic [1:0]            r_mode;
  logic [LW-1:0]         r_dim;
  logic [EXT_WIDTH-1:0]  r_ext [LOOP_LEVEL];
  logic [CNT_WIDTH-1:0]  r_stride [LOOP_LEVEL];
  logic [EXT_WIDTH-1:0]  r_it [LOOP_LEVEL];
  logic [EXT_WIDTH-1:0]  w_it_nx [LOOP_LEVEL];
  logic [LOOP_LEVEL:0]   w_carry;
  logic [CNT_WIDTH-1:0]  r_cnt, w_tgt;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wp, r_rp;
  logic [DATA_WIDTH-1:0] r_word, w_head;
  logic                  r_str, r_err, r_fin;
  logic                  w_empty, w_full, w_run, w_start, w_match, w_xfer, w_adv, w_last, w_push, w_pop;

  assign w_empty = r_wp == r_rp;
  assign w_full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_head = r_mem[r_rp[AW-1:0]];
  assign w_run = r_state == RUN;
  assign w_start = i_cfg_start && !w_run && (i_cfg_mode == 2'd1 || i_cfg_mode == 2'd2) && i_cfg_dim != '0;
  assign w_match = w_run && r_mode == 2'd1 && !i_stall && !r_fin && r_cnt == w_tgt;
  assign w_xfer = o_io16_g2io_vld && i_io16_g2io_rdy;
  assign w_adv = w_match || w_xfer;
  assign w_pop = (w_match && !w_empty) || w_xfer;
  assign w_push = i_src_vld && o_src_rdy;
  assign w_last = w_carry[r_dim];

  assign o_src_rdy = !w_full && !reset;
  assign o_io16_g2io_vld = w_run && r_mode == 2'd2 && !w_empty && !i_stall;
  assign o_io16_g2io = o_io16_g2io_vld ? w_head : r_word;
  assign o_io1_g2io = r_str;
  assign o_busy = w_run;
  assign o_done = r_state == DONE;
  assign o_err_underflow = r_err;

  // r_ext holds extent-1, so the carry chain reaching level dim marks the final word
  always_comb begin
    w_tgt = '0;
    w_carry = '0;
    w_carry[0] = 1'b1;
    for (int k = 0; k < LOOP_LEVEL; k++) begin
      w_tgt = w_tgt + CNT_WIDTH'(r_it[k]) * r_stride[k];
      w_carry[k+1] = w_carry[k] && r_it[k] == r_ext[k];
      w_it_nx[k] = !w_carry[k] ? r_it[k] : w_carry[k+1] ? '0 : r_it[k] + EXT_WIDTH'(1);
    end
  end

  // VALID mode stays in RUN for the strobe cycle so busy falls together with done
  always_comb begin
    w_nstate = r_state;
    if (i_flush)
      w_nstate = IDLE;
    else if (w_start)
      w_nstate = RUN;
    else if (w_run && (r_fin || (w_xfer && w_last)))
      w_nstate = DONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_nstate;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || i_flush) begin
      r_mode <= '0;
      r_dim <= '0;
      r_cnt <= '0;
      r_str <= 1'b0;
      r_word <= '0;
      r_err <= 1'b0;
      r_fin <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
      for (int k = 0; k < LOOP_LEVEL; k++) begin
        r_ext[k] <= '0;
        r_stride[k] <= '0;
        r_it[k] <= '0;
      end
    end else begin
      r_str <= w_match;
      r_word <= (w_match && !w_empty) ? w_head : '0;
      r_fin <= w_match && w_last;
      if (w_start) begin
        r_mode <= i_cfg_mode;
        r_dim <= i_cfg_dim;
        r_cnt <= '0;
        r_err <= 1'b0;
        for (int k = 0; k < LOOP_LEVEL; k++) begin
          r_ext[k] <= (i_cfg_extent[k*EXT_WIDTH +: EXT_WIDTH] == '0) ? '0 : i_cfg_extent[k*EXT_WIDTH +: EXT_WIDTH] - EXT_WIDTH'(1);
          r_stride[k] <= i_cfg_cycle_stride[k*CNT_WIDTH +: CNT_WIDTH];
          r_it[k] <= '0;
        end
      end else begin
        if (w_run && r_mode == 2'd1 && !i_stall)
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        if (w_adv)
          for (int k = 0; k < LOOP_LEVEL; k++)
            r_it[k] <= w_last ? '0 : w_it_nx[k];
        if (w_match && w_empty)
          r_err <= 1'b1;
      end
      if (w_push)
        r_wp <= r_wp + (AW+1)'(1);
      if (w_pop)
        r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush)
      r_mem[r_wp[AW-1:0]] <= i_src_data;
  end
endmodule
